// File: rtl/axi_stream_header_insert.sv
// axi_stream_header_insert: prepends a side-channel header's valid bytes to the next AXI-Stream packet
// Ports: clk/rst_n (async active-low); valid_in/data_in/keep_in/last_in/ready_in = packet sink;
// valid_out/data_out/keep_out/last_out/ready_out = registered merged stream source;
// valid_insert/data_insert/keep_insert/byte_insert_cnt/ready_insert = header sink (LSB-aligned bytes).
module axi_stream_header_insert #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
  parameter int BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [DATA_BYTE_WIDTH-1:0] keep_in,
  input  logic                       last_in,
  output logic                       ready_in,
  output logic                       valid_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [DATA_BYTE_WIDTH-1:0] keep_out,
  output logic                       last_out,
  input  logic                       ready_out,
  input  logic                       valid_insert,
  input  logic [DATA_WIDTH-1:0]      data_insert,
  input  logic [DATA_BYTE_WIDTH-1:0] keep_insert,
  input  logic [BYTE_CNT_WIDTH-1:0]  byte_insert_cnt,
  output logic                       ready_insert
);
  localparam int W  = DATA_BYTE_WIDTH;
  localparam int CW = BYTE_CNT_WIDTH + 2;
  localparam logic [W-1:0] ONES = '1;
  typedef enum logic [1:0] {S_HDR, S_DATA, S_TAIL} state_t;
  // Top k byte enables set (MSB-aligned); k = W yields all ones since the shift empties.
  function automatic logic [W-1:0] f_top(input logic [CW-1:0] k);
    return ~(ONES >> k);
  endfunction
  // Low k byte enables set (LSB-aligned).
  function automatic logic [W-1:0] f_low(input logic [CW-1:0] k);
    return ~(ONES << k);
  endfunction
  function automatic logic [DATA_WIDTH-1:0] f_bytes(input logic [W-1:0] k);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < W; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction
  state_t                  r_state, w_state;
  logic [DATA_WIDTH-1:0]   r_res, w_res, r_data, w_data;
  logic [W-1:0]            r_keep, w_keep;
  logic                    r_valid, w_valid, r_last, w_last;
  logic [CW-1:0]           r_n, w_n, r_r, w_r, w_m, w_sum, w_hdr_n, w_pad;
  logic [2*DATA_WIDTH-1:0] w_cat;
  logic                    w_slot;
  assign w_slot       = !r_valid || ready_out;
  assign ready_insert = r_state == S_HDR;
  assign ready_in     = r_state == S_DATA && w_slot;
  assign valid_out    = r_valid;
  assign data_out     = r_data;
  assign keep_out     = r_keep;
  assign last_out     = r_last;
  assign w_hdr_n      = CW'(byte_insert_cnt) + CW'(1);
  assign w_sum        = r_n + w_m;
  assign w_pad        = CW'(W) - r_n;
  // Residual (N bytes, LSB-aligned) followed by the new beat; shifting right by N bytes
  // leaves {residual, top W-N bytes of data_in} in the low word.
  assign w_cat        = {r_res, data_in} >> {r_n, 3'b000};
  always_comb begin
    w_m = '0;
    for (int i = 0; i < W; i++) w_m = w_m + CW'(keep_in[i]);
  end
  always_comb begin
    w_state = r_state;
    w_res   = r_res;
    w_n     = r_n;
    w_r     = r_r;
    w_data  = r_data;
    w_keep  = r_keep;
    w_last  = r_last;
    w_valid = r_valid && !ready_out;
    case (r_state)
      S_HDR: if (valid_insert) begin
        w_n     = w_hdr_n;
        w_res   = data_insert & f_bytes(f_low(w_hdr_n) & keep_insert);
        w_state = S_DATA;
      end
      S_DATA: if (valid_in && w_slot) begin
        w_valid = 1'b1;
        w_res   = data_in & f_bytes(f_low(r_n));
        w_last  = last_in && w_sum <= CW'(W);
        w_keep  = w_last ? f_top(w_sum) : ONES;
        w_data  = w_cat[DATA_WIDTH-1:0] & f_bytes(w_keep);
        w_r     = w_sum - CW'(W);
        w_state = !last_in ? S_DATA : w_last ? S_HDR : S_TAIL;
      end
      S_TAIL: if (w_slot) begin
        // Only the top R of the N held bytes belong to the packet; the rest is masked off.
        w_valid = 1'b1;
        w_keep  = f_top(r_r);
        w_data  = (r_res << {w_pad, 3'b000}) & f_bytes(w_keep);
        w_last  = 1'b1;
        w_res   = '0;
        w_state = S_HDR;
      end
      default: w_state = S_HDR;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_HDR;
      r_res   <= '0;
      r_n     <= '0;
      r_r     <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_res   <= w_res;
      r_n     <= w_n;
      r_r     <= w_r;
      r_data  <= w_data;
      r_keep  <= w_keep;
      r_last  <= w_last;
      r_valid <= w_valid;
    end
endmodule

// File: tb/tb_axi_stream_header_insert.sv
// tb_axi_stream_header_insert: table vectors, corner sequences and randomized packets vs a byte-queue model
module tb_axi_stream_header_insert;
  localparam int W  = 4;
  localparam int DW = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic valid_in, last_in, ready_in, valid_out, last_out, ready_out, valid_insert, ready_insert;
  logic [DW-1:0] data_in, data_out, data_insert;
  logic [W-1:0] keep_in, keep_out, keep_insert;
  logic [1:0] byte_insert_cnt;
  always #5 clk = ~clk;
  axi_stream_header_insert dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert)
  );
  int tests = 0, fails = 0;
  logic [DW-1:0] exp_d[$], obs_d[$];
  logic [W-1:0] exp_k[$], obs_k[$];
  logic exp_l[$], obs_l[$];
  logic [7:0] pkt[$];
  bit ro_rand = 1'b0;
  typedef struct {
    int n; logic [31:0] hdr; int nb; logic [1:0][31:0] d; logic [3:0] lk;
    int ne; logic [2:0][31:0] ed; logic [2:0][3:0] ek;
  } vec_t;
  vec_t tbl[5];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask
  // Reference: header bytes (MSB-first of the low N) then payload bytes, cut into W-byte beats.
  function automatic void model(input int n, input logic [DW-1:0] hdr);
    logic [7:0] q[$];
    logic [DW-1:0] d;
    logic [W-1:0] k;
    for (int i = n - 1; i >= 0; i--) q.push_back(hdr[i*8 +: 8]);
    foreach (pkt[i]) q.push_back(pkt[i]);
    while (q.size() > 0) begin
      d = '0;
      k = '0;
      for (int j = 0; j < W; j++)
        if (q.size() > 0) begin
          d[DW-1-8*j -: 8] = q.pop_front();
          k[W-1-j] = 1'b1;
        end
      exp_d.push_back(d);
      exp_k.push_back(k);
      exp_l.push_back(q.size() == 0);
    end
  endfunction
  logic hold_v = 1'b0, hold_l;
  logic [DW-1:0] hold_d;
  logic [W-1:0] hold_k;
  always @(negedge clk) begin
    if (!rst_n) hold_v <= 1'b0;
    else begin
      if (hold_v) begin
        check("hold_valid", valid_out, 1);
        check("hold_data", data_out, hold_d);
        check("hold_keep", keep_out, hold_k);
        check("hold_last", last_out, hold_l);
      end
      if (valid_out && ready_out) begin
        obs_d.push_back(data_out);
        obs_k.push_back(keep_out);
        obs_l.push_back(last_out);
      end
      hold_v <= valid_out && !ready_out;
      hold_d <= data_out;
      hold_k <= keep_out;
      hold_l <= last_out;
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (ro_rand) ready_out = ($urandom_range(0, 3) != 0);
  end
  task automatic send_hdr(input int n, input logic [DW-1:0] hdr);
    int t;
    valid_insert = 1'b1;
    data_insert = hdr;
    byte_insert_cnt = 2'(n - 1);
    keep_insert = 4'((1 << n) - 1);
    for (t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (ready_insert) break;
    end
    if (t == 1000) check("hdr_timeout", 0, 1);
    @(posedge clk);
    #1;
    valid_insert = 1'b0;
  endtask
  task automatic send_beat(input logic [DW-1:0] d, input logic [W-1:0] k, input logic l);
    int t;
    valid_in = 1'b1;
    data_in = d;
    keep_in = k;
    last_in = l;
    for (t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (ready_in) break;
    end
    if (t == 1000) check("beat_timeout", 0, 1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask
  task automatic send_pkt(input int n, input logic [DW-1:0] hdr, input int gmax);
    int idx = 0;
    logic [DW-1:0] d;
    logic [W-1:0] k;
    send_hdr(n, hdr);
    while (idx < pkt.size()) begin
      repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
      d = $urandom;
      k = '0;
      for (int j = 0; j < W; j++)
        if (idx < pkt.size()) begin
          d[DW-1-8*j -: 8] = pkt[idx];
          idx++;
          k[W-1-j] = 1'b1;
        end
      send_beat(d, k, idx == pkt.size());
    end
  endtask
  task automatic drain(input string name);
    int t = 0;
    while (obs_d.size() < exp_d.size() && t < 5000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    check({name, "_count"}, obs_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      check($sformatf("%s_data%0d", name, i), obs_d[i], exp_d[i]);
      check($sformatf("%s_keep%0d", name, i), obs_k[i], exp_k[i]);
      check($sformatf("%s_last%0d", name, i), obs_l[i], exp_l[i]);
    end
    exp_d.delete(); exp_k.delete(); exp_l.delete();
    obs_d.delete(); obs_k.delete(); obs_l.delete();
    @(posedge clk);
    #1;
  endtask
  initial begin
    valid_in = 0; data_in = 0; keep_in = 0; last_in = 0; ready_out = 1;
    valid_insert = 0; data_insert = 0; keep_insert = 0; byte_insert_cnt = 0;
    tbl[0] = '{2, 32'h0000AABB, 2, {32'h55667788, 32'h11223344}, 4'hF, 3,
               {32'h77880000, 32'h33445566, 32'hAABB1122}, {4'hC, 4'hF, 4'hF}};
    tbl[1] = '{2, 32'hFFFFAABB, 2, {32'h556699AA, 32'h11223344}, 4'hC, 2,
               {32'h0, 32'h33445566, 32'hAABB1122}, {4'h0, 4'hF, 4'hF}};
    tbl[2] = '{4, 32'hDEADBEEF, 2, {32'h55667788, 32'h11223344}, 4'hF, 3,
               {32'h55667788, 32'h11223344, 32'hDEADBEEF}, {4'hF, 4'hF, 4'hF}};
    tbl[3] = '{1, 32'h777777CC, 1, {32'h0, 32'h11223344}, 4'h8, 1,
               {32'h0, 32'h0, 32'hCC110000}, {4'h0, 4'h0, 4'hC}};
    tbl[4] = '{3, 32'h99112233, 1, {32'h0, 32'hAABBCCDD}, 4'hE, 2,
               {32'h0, 32'hBBCC0000, 32'h112233AA}, {4'h0, 4'hC, 4'hF}};
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_keep_out", keep_out, 0);
    check("rst_last_out", last_out, 0);
    check("rst_ready_insert", ready_insert, 1);
    check("rst_ready_in", ready_in, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int v = 0; v < 5; v++) begin
      for (int e = 0; e < tbl[v].ne; e++) begin
        exp_d.push_back(tbl[v].ed[e]);
        exp_k.push_back(tbl[v].ek[e]);
        exp_l.push_back(e == tbl[v].ne - 1);
      end
      send_hdr(tbl[v].n, tbl[v].hdr);
      for (int b = 0; b < tbl[v].nb; b++)
        send_beat(tbl[v].d[b], b == tbl[v].nb - 1 ? tbl[v].lk : 4'hF, b == tbl[v].nb - 1);
      drain($sformatf("vec%0d", v));
    end
    send_hdr(1, 32'hFFFFFFCC);
    send_beat(32'h11223344, 4'h8, 1'b1);
    check("n1_ready_insert_back", ready_insert, 1);
    check("n1_ready_in_low", ready_in, 0);
    exp_d.push_back(32'hCC110000); exp_k.push_back(4'hC); exp_l.push_back(1'b1);
    drain("n1");
    pkt.delete();
    for (int i = 0; i < 22; i++) pkt.push_back(8'(i + 1));
    model(2, 32'h1234A1B2);
    fork
      send_pkt(2, 32'h1234A1B2, 0);
      begin
        int t = 0;
        while (obs_d.size() < 2 && t < 200) begin @(negedge clk); t++; end
        @(posedge clk);
        #1;
        ready_out = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_ready_in", ready_in, 0);
          check("stall_valid_out", valid_out, 1);
        end
        @(posedge clk);
        #1;
        ready_out = 1'b1;
      end
    join
    drain("stall");
    send_hdr(3, 32'h00ABCDEF);
    send_beat(32'h01020304, 4'hF, 1'b0);
    send_beat(32'h05060708, 4'hF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid_out", valid_out, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_keep_out", keep_out, 0);
    check("midrst_last_out", last_out, 0);
    check("midrst_ready_insert", ready_insert, 1);
    check("midrst_ready_in", ready_in, 0);
    obs_d.delete(); obs_k.delete(); obs_l.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pkt.delete();
    pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33);
    exp_d.push_back(32'hAABB1122); exp_k.push_back(4'hF); exp_l.push_back(1'b0);
    exp_d.push_back(32'h33000000); exp_k.push_back(4'h8); exp_l.push_back(1'b1);
    send_pkt(2, 32'hFFFFAABB, 0);
    drain("post_reset");
    ro_rand = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int n, len;
      logic [DW-1:0] hdr;
      n = $urandom_range(1, 4);
      len = $urandom_range(1, 13);
      hdr = $urandom;
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      model(n, hdr);
      send_pkt(n, hdr, 2);
    end
    ro_rand = 1'b0;
    ready_out = 1'b1;
    drain("rand");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
